// File: rtl/touch_report_tx.sv
// touch_report_tx: stand-in touch panel UART transmitter.
// Each accepted report is sent as a 5-byte touch packet, 8N1, LSB first:
//   B0 = {7'b1000000, pen_down}, B1 = {1'b0, x[6:0]}, B2 = {3'b0, x[11:7]},
//   B3 = {1'b0, y[6:0]},         B4 = {3'b0, y[11:7]}
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   report_valid report offered on pen_down / x_pos / y_pos
//   report_ready block can accept a report this cycle (registered)
//   pen_down     1 = pen touching, 0 = lifted
//   x_pos, y_pos 12-bit coordinates
//   txd          serial line, idles high, driven straight from a flop
//   busy         packet in flight (!report_ready)
//   packets_sent count of fully transmitted packets, wraps
module touch_report_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             report_valid,
  output logic             report_ready,
  input  logic             pen_down,
  input  logic [11:0]      x_pos,
  input  logic [11:0]      y_pos,
  output logic             txd,
  output logic             busy,
  output logic [CNT_W-1:0] packets_sent
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic [39:0]        packet_q, packet_d;
  logic               txd_q, txd_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               xfer;
  logic               timer_end;
  logic [7:0]         cur_byte;

  assign xfer      = report_valid && ready_q;
  assign timer_end = (timer_q == TimerMax);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    packet_d = packet_q;
    cnt_d    = cnt_q;

    if (state_q != StIdle) begin
      timer_d = timer_end ? '0 : timer_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d  = StStart;
          timer_d  = '0;
          bit_d    = '0;
          byte_d   = '0;
          packet_d = {3'b000, y_pos[11:7], 1'b0, y_pos[6:0],
                      3'b000, x_pos[11:7], 1'b0, x_pos[6:0],
                      7'b1000000, pen_down};
        end
      end
      StStart: begin
        if (timer_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (timer_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (timer_end) begin
          if (byte_q == 3'd4) begin
            state_d = StIdle;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            // Next byte's start bit follows the stop bit with no gap.
            byte_d  = byte_q + 3'd1;
            state_d = StStart;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte select uses the next byte index so txd_d lines up with the next state.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_d)
      3'd0:    cur_byte = packet_q[7:0];
      3'd1:    cur_byte = packet_q[15:8];
      3'd2:    cur_byte = packet_q[23:16];
      3'd3:    cur_byte = packet_q[31:24];
      3'd4:    cur_byte = packet_q[39:32];
      default: cur_byte = 8'h00;
    endcase
  end

  // txd and report_ready are computed from the next state so they change on the
  // same edge the state does, with no combinational path to the outputs.
  always_comb begin
    txd_d   = 1'b1;
    ready_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
      end
      StStart: txd_d = 1'b0;
      StData:  txd_d = cur_byte[bit_d];
      StStop:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      packet_q <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      packet_q <= packet_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  assign txd          = txd_q;
  assign report_ready = ready_q;
  assign busy         = ~ready_q;
  assign packets_sent = cnt_q;

endmodule

// File: tb/tb_touch_report_tx.sv
module tb_touch_report_tx;

  localparam int CPB = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          report_valid = 1'b0;
  logic          pen_down = 1'b0;
  logic [11:0]   x_pos = '0;
  logic [11:0]   y_pos = '0;
  logic          report_ready;
  logic          txd;
  logic          busy;
  logic [CW-1:0] packets_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer_edge = 0;
  int n_xfer = 0;

  touch_report_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (CW)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .pen_down    (pen_down),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .txd         (txd),
    .busy        (busy),
    .packets_sent(packets_sent)
  );

  always #5 clk = ~clk;

  // Edge counter; xfer_edge is the index of the edge where the last transfer happened.
  always @(posedge clk) begin
    if (report_valid && report_ready) begin
      xfer_edge <= cyc + 1;
      n_xfer    <= n_xfer + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a start bit, then samples each bit in its second cycle.
  task automatic recv_byte(output logic [7:0] b, output bit framing_ok, output bit got);
    int n;
    b = 8'h00;
    framing_ok = 1'b1;
    got = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (txd !== 1'b0 && n < 300);
    if (txd !== 1'b0) return;
    got = 1'b1;
    for (int k = 1; k < CPB; k++) begin
      tick();
      if (txd !== 1'b0) framing_ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < CPB; k++) begin
        tick();
        if (k == 1) b[i] = txd;
      end
    end
    for (int k = 0; k < CPB; k++) begin
      tick();
      if (txd !== 1'b1) framing_ok = 1'b0;
    end
  endtask

  task automatic recv_packet(input string tag, input logic [39:0] exp, input bit hold_valid,
                             input logic [11:0] x_after_b0);
    logic [7:0] b;
    bit fok, got, all_fok;
    all_fok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      recv_byte(b, fok, got);
      if (i == 0) begin
        if (!hold_valid) report_valid = 1'b0;
        x_pos = x_after_b0;
      end
      check($sformatf("%s_got_b%0d", tag, i), 32'(got), 32'd1);
      check($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[8*i +: 8]));
      all_fok &= fok;
    end
    check($sformatf("%s_framing", tag), 32'(all_fok), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int limit);
    int n;
    n = 0;
    while (report_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check($sformatf("%s_ready_seen", tag), 32'(report_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_edge;
    int lows;
    logic [7:0] b;
    bit fok, got;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(report_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(packets_sent), 32'd0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("idle_txd_high", 32'(lows), 32'd0);

    // Pen-down report.
    pen_down = 1'b1;
    x_pos = 12'd2048;
    y_pos = 12'd255;
    report_valid = 1'b1;
    recv_packet("pd", {8'h01, 8'h7F, 8'h10, 8'h00, 8'h81}, 1'b0, 12'd2048);
    wait_ready("pd", 20);
    check("pd_ready_latency", 32'(cyc - xfer_edge), 32'd200);
    check("pd_cnt", 32'(packets_sent), 32'd1);
    check("pd_one_xfer", 32'(n_xfer), 32'd1);

    // Pen-up extremes.
    pen_down = 1'b0;
    x_pos = 12'd4095;
    y_pos = 12'd0;
    report_valid = 1'b1;
    recv_packet("pu", {8'h00, 8'h00, 8'h1F, 8'h7F, 8'h80}, 1'b0, 12'd4095);
    wait_ready("pu", 20);
    check("pu_cnt", 32'(packets_sent), 32'd2);

    // Valid held through a packet; X changes during B1.
    pen_down = 1'b1;
    x_pos = 12'd100;
    y_pos = 12'd0;
    report_valid = 1'b1;
    recv_packet("bz1", {8'h00, 8'h00, 8'h00, 8'h64, 8'h81}, 1'b1, 12'd200);
    first_edge = xfer_edge;
    recv_packet("bz2", {8'h00, 8'h00, 8'h01, 8'h48, 8'h81}, 1'b0, 12'd200);
    check("bz_back_to_back", 32'(xfer_edge - first_edge), 32'd201);
    wait_ready("bz", 20);
    check("bz_cnt", 32'(packets_sent), 32'd4);

    // Reset during bit 3 of B2.
    x_pos = 12'h555;
    y_pos = 12'h2AA;
    report_valid = 1'b1;
    recv_byte(b, fok, got);
    report_valid = 1'b0;
    check("rm_b0", 32'(b), 32'h81);
    recv_byte(b, fok, got);
    check("rm_b1", 32'(b), 32'h55);
    for (int i = 0; i < 4 * CPB + 1; i++) tick();
    check("rm_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_txd", 32'(txd), 32'd1);
    check("rm_ready", 32'(report_ready), 32'd1);
    check("rm_cnt", 32'(packets_sent), 32'd0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("rm_no_more_bytes", 32'(lows), 32'd0);

    // Sixteen back-to-back packets wrap the 4-bit counter.
    pen_down = 1'b0;
    x_pos = '0;
    y_pos = '0;
    report_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 5) begin
        tick();
        n++;
      end
      check($sformatf("wr_busy%0d", k), 32'(busy), 32'd1);
      wait_ready($sformatf("wr%0d", k), 250);
      if (k == 16) report_valid = 1'b0;
      check($sformatf("wr_cnt%0d", k), 32'(packets_sent), 32'(k % 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
